banked_pmem: RTL and testbench

Parametrised multi-channel physical memory for the pipelined processor bench. It replaces the single-port line memory with `NUM_CH` independent requesters (e.g. I-cache and D-cache) sharing one line store. Requests are arbitrated round-robin and serviced with a fixed, configurable latency. A sticky protocol-error flag is provided for verification.

---
 rtl/pmem_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/banked_pmem.sv | 151 +++++++++++++++
 tb/tb_banked_pmem.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared types for the banked physical memory: FSM states, operation kind,
// and the byte-offset width of a line address.
package pmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } pmem_state_t;

   typedef enum logic {
      READ,
      WRITE
   } pmem_op_t;

   function automatic int offset_bits(input int line_w);
      return $clog2(line_w / 8);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting channel at or after ptr,
// wrapping around the channel count.
module rr_arbiter #(
   parameter int NUM_CH = 2,
   parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [IDX_W-1:0]  grant_idx
);

   logic [IDX_W:0] cand;
   logic           found;

   // Walk downwards so the smallest distance from ptr is the last one kept.
   always_comb begin
      cand      = '0;
      found     = 1'b0;
      grant_idx = '0;
      for (int j = NUM_CH - 1; j >= 0; j--) begin
         cand = {1'b0, ptr} + (IDX_W + 1)'(j);
         if (cand >= (IDX_W + 1)'(NUM_CH)) begin
            cand = cand - (IDX_W + 1)'(NUM_CH);
         end
         if (req[cand[IDX_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
      grant = found ? (NUM_CH'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/banked_pmem.sv
// Multi-channel line memory: round-robin arbitration over NUM_CH requesters,
// fixed-latency service, one-cycle resp pulse and a sticky protocol-error flag.
module banked_pmem
   import pmem_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 16,
   parameter int LINE_W  = 128,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CH-1:0]              pmem_read,
   input  logic [NUM_CH-1:0]              pmem_write,
   input  logic [NUM_CH-1:0][ADDR_W-1:0]  pmem_address,
   input  logic [NUM_CH-1:0][LINE_W-1:0]  pmem_wdata,
   output logic [NUM_CH-1:0]              pmem_resp,
   output logic [LINE_W-1:0]              pmem_rdata,
   output logic                           err
);

   localparam int OFF_W  = offset_bits(LINE_W);
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int LIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   pmem_state_t       state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  rr_ptr, gnt_idx, arb_idx;
   logic [NUM_CH-1:0] req, arb_grant;
   logic              accept, done;

   logic [LINE_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] sel_addr;
   logic [LINE_W-1:0] sel_wdata, lat_wdata, cur_wdata;
   logic [LIDX_W-1:0] sel_line, lat_line, cur_line;
   logic              sel_rd, sel_wr, lat_rd, cur_rd;
   pmem_op_t          lat_op, cur_op;
   logic              unused_addr_bits;

   assign req = pmem_read | pmem_write;

   rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
      .req       (req),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_rd    = 1'b0;
      sel_wr    = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (arb_grant[i]) begin
            sel_addr  = sel_addr | pmem_address[i];
            sel_wdata = sel_wdata | pmem_wdata[i];
            sel_rd    = sel_rd | pmem_read[i];
            sel_wr    = sel_wr | pmem_write[i];
         end
      end
   end

   // Offset bits and aliasing upper bits carry no meaning for the line store.
   assign sel_line         = sel_addr[OFF_W +: LIDX_W];
   assign unused_addr_bits = ^sel_addr;

   // With LATENCY=1 the op completes on the accept edge, straight from the inputs.
   assign cur_line  = (state == IDLE) ? sel_line : lat_line;
   assign cur_wdata = (state == IDLE) ? sel_wdata : lat_wdata;
   assign cur_op    = (state == IDLE) ? (sel_wr ? WRITE : READ) : lat_op;
   assign cur_rd    = (state == IDLE) ? sel_rd : lat_rd;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  done      = 1'b1;
                  state_nxt = RESP;
               end else begin
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt == CNT_W'(1)) begin
               done      = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         rr_ptr     <= '0;
         gnt_idx    <= '0;
         err        <= 1'b0;
         pmem_rdata <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            gnt_idx <= arb_idx;
            cnt     <= CNT_W'(LATENCY - 1);
            if (sel_rd && sel_wr) begin
               err <= 1'b1;
            end
         end else if (state == BUSY) begin
            cnt <= cnt - 1'b1;
         end
         // A combined read+write returns the line being written.
         if (done && cur_rd) begin
            pmem_rdata <= (cur_op == WRITE) ? cur_wdata : mem[cur_line];
         end
         if (state == RESP) begin
            rr_ptr <= (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_line  <= sel_line;
         lat_wdata <= sel_wdata;
         lat_op    <= sel_wr ? WRITE : READ;
         lat_rd    <= sel_rd;
      end
   end

   // Reset on the completion edge suppresses the commit.
   always_ff @(posedge clk) begin
      if (rst_n && done && (cur_op == WRITE)) begin
         mem[cur_line] <= cur_wdata;
      end
   end

   assign pmem_resp = (state == RESP) ? (NUM_CH'(1) << gnt_idx) : '0;

endmodule

// File: tb/tb_banked_pmem.sv
// Randomised self-checking bench for banked_pmem: a LATENCY=4 instance and a
// LATENCY=1 instance, checked against a line-level reference model.
module tb_banked_pmem;

   localparam int NUM_CH = 2;
   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;
   localparam int DEPTH  = 256;
   localparam int LAT_A  = 4;
   localparam int LAT_B  = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [NUM_CH-1:0]             rd_a, wr_a, resp_a;
   logic [NUM_CH-1:0][ADDR_W-1:0] addr_a;
   logic [NUM_CH-1:0][LINE_W-1:0] wdata_a;
   logic [LINE_W-1:0]             rdata_a;
   logic                          err_a;

   logic [NUM_CH-1:0]             rd_b, wr_b, resp_b;
   logic [NUM_CH-1:0][ADDR_W-1:0] addr_b;
   logic [NUM_CH-1:0][LINE_W-1:0] wdata_b;
   logic [LINE_W-1:0]             rdata_b;
   logic                          err_b;

   banked_pmem #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W),
                 .DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .pmem_read    (rd_a),
      .pmem_write   (wr_a),
      .pmem_address (addr_a),
      .pmem_wdata   (wdata_a),
      .pmem_resp    (resp_a),
      .pmem_rdata   (rdata_a),
      .err          (err_a)
   );

   banked_pmem #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W),
                 .DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .pmem_read    (rd_b),
      .pmem_write   (wr_b),
      .pmem_address (addr_b),
      .pmem_wdata   (wdata_b),
      .pmem_resp    (resp_b),
      .pmem_rdata   (rdata_b),
      .err          (err_b)
   );

   // Reference model: line contents, expected rdata/err, next priority channel.
   logic [LINE_W-1:0] ref_mem [int];
   logic [LINE_W-1:0] exp_rdata;
   logic              exp_err;
   int                next_pri;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int line_of(input logic [ADDR_W-1:0] a);
      return (int'(a) / (LINE_W / 8)) % DEPTH;
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One transaction on instance A, starting from an idle DUT.
   task automatic txn_a(input int ch, input logic rd, input logic wr,
                        input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wd,
                        input string tag);
      int n;
      bit got;
      int ln;
      logic [NUM_CH-1:0] seen;
      @(negedge clk);
      rd_a[ch]    = rd;
      wr_a[ch]    = wr;
      addr_a[ch]  = addr;
      wdata_a[ch] = wd;
      n    = 0;
      got  = 1'b0;
      seen = '0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (resp_a != '0) begin
            got  = 1'b1;
            seen = resp_a;
         end
      end
      rd_a[ch] = 1'b0;
      wr_a[ch] = 1'b0;
      ln = line_of(addr);
      if (wr) ref_mem[ln] = wd;
      if (rd) exp_rdata = wr ? wd : ref_mem[ln];
      if (rd && wr) exp_err = 1'b1;
      next_pri = (ch + 1) % NUM_CH;
      chk({tag, "_lat"}, LINE_W'(n), LINE_W'(LAT_A));
      chk({tag, "_resp"}, LINE_W'(seen), LINE_W'(1 << ch));
      chk({tag, "_rdata"}, rdata_a, exp_rdata);
      chk({tag, "_err"}, LINE_W'(err_a), LINE_W'(exp_err));
      @(negedge clk);
      chk({tag, "_pulse"}, LINE_W'(resp_a), '0);
   endtask

   // Both channels read in the same cycle; the model decides the service order.
   task automatic contend(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1, input string tag);
      int t_resp[2];
      int n;
      int first;
      int second;
      logic [LINE_W-1:0] exp_d[2];
      exp_d[0] = ref_mem[line_of(a0)];
      exp_d[1] = ref_mem[line_of(a1)];
      first  = next_pri;
      second = 1 - first;
      @(negedge clk);
      rd_a      = 2'b11;
      addr_a[0] = a0;
      addr_a[1] = a1;
      t_resp[0] = -1;
      t_resp[1] = -1;
      n = 0;
      while ((t_resp[0] < 0 || t_resp[1] < 0) && n < 30) begin
         @(negedge clk);
         n++;
         for (int c = 0; c < 2; c++) begin
            if (resp_a[c] && t_resp[c] < 0) begin
               t_resp[c] = n;
               rd_a[c]   = 1'b0;
               chk({tag, "_rdata"}, rdata_a, exp_d[c]);
            end
         end
      end
      rd_a = '0;
      chk({tag, "_first"}, LINE_W'(t_resp[first]), LINE_W'(LAT_A));
      chk({tag, "_second"}, LINE_W'(t_resp[second]), LINE_W'(2 * LAT_A + 1));
      exp_rdata = exp_d[second];
      next_pri  = (second + 1) % NUM_CH;
      @(negedge clk);
      chk({tag, "_pulse"}, LINE_W'(resp_a), '0);
   endtask

   // Write to line 5, then reset `delay` cycles after the request cycle.
   task automatic reset_mid(input int delay, input string tag);
      bit saw;
      @(negedge clk);
      wr_a[0]    = 1'b1;
      addr_a[0]  = 16'h0050;
      wdata_a[0] = ~ref_mem[5];
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk({tag, "_busy_resp"}, LINE_W'(resp_a), '0);
      end
      rst_n   = 1'b0;
      wr_a[0] = 1'b0;
      @(negedge clk);
      chk({tag, "_rst_resp"}, LINE_W'(resp_a), '0);
      chk({tag, "_rst_rdata"}, rdata_a, '0);
      chk({tag, "_rst_err"}, LINE_W'(err_a), '0);
      rst_n     = 1'b1;
      exp_rdata = '0;
      exp_err   = 1'b0;
      next_pri  = 0;
      saw = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (resp_a != '0) saw = 1'b1;
      end
      chk({tag, "_no_resp"}, LINE_W'(saw), '0);
      txn_a(1, 1'b1, 1'b0, 16'h0050, '0, {tag, "_line5"});
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pool[8];
      int n;
      bit got;
      logic [LINE_W-1:0] vb;
      logic [ADDR_W-1:0] a;

      rst_n = 1'b0;
      rd_a = '0; wr_a = '0; addr_a = '0; wdata_a = '0;
      rd_b = '0; wr_b = '0; addr_b = '0; wdata_b = '0;
      exp_rdata = '0;
      exp_err   = 1'b0;
      next_pri  = 0;
      repeat (3) @(negedge clk);
      chk("rst_resp_a", LINE_W'(resp_a), '0);
      chk("rst_rdata_a", rdata_a, '0);
      chk("rst_err_a", LINE_W'(err_a), '0);
      chk("rst_resp_b", LINE_W'(resp_b), '0);
      chk("rst_rdata_b", rdata_b, '0);
      rst_n = 1'b1;

      txn_a(1, 1'b0, 1'b1, 16'h0120, rand_line(), "preload12");
      txn_a(0, 1'b1, 1'b0, 16'h0120, '0, "read12");

      txn_a(1, 1'b0, 1'b1, 16'h0A30, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, "wr_a30");
      txn_a(1, 1'b1, 1'b0, 16'h0A3F, '0, "rd_a3f");
      txn_a(0, 1'b1, 1'b0, 16'h1A30, '0, "rd_1a30");

      txn_a(0, 1'b0, 1'b1, 16'h0050, rand_line(), "preload5");

      for (int i = 0; i < 8; i++) begin
         pool[i] = $urandom_range(0, DEPTH - 1);
         txn_a(int'($urandom_range(0, 1)), 1'b0, 1'b1, ADDR_W'(pool[i] * 16), rand_line(), "pool_wr");
      end
      for (int i = 0; i < 30; i++) begin
         a = ADDR_W'(pool[$urandom_range(0, 7)] * 16 + $urandom_range(0, 15) + 4096 * $urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1)
            txn_a(int'($urandom_range(0, 1)), 1'b1, 1'b0, a, '0, "rnd_rd");
         else
            txn_a(int'($urandom_range(0, 1)), 1'b0, 1'b1, a, rand_line(), "rnd_wr");
      end

      txn_a(1, 1'b1, 1'b0, 16'h0120, '0, "pre_contend");
      contend(16'h0120, 16'h0A30, "contend1");
      contend(16'h0A30, 16'h0050, "contend2");

      txn_a(0, 1'b1, 1'b1, 16'h0770, rand_line(), "rw_both");
      txn_a(1, 1'b1, 1'b0, 16'h0770, '0, "after_both");

      reset_mid(2, "rst_mid");
      reset_mid(3, "rst_edge");

      // LATENCY=1 instance: single write, then a held read.
      vb = rand_line();
      @(negedge clk);
      wr_b[0]    = 1'b1;
      addr_b[0]  = 16'h0030;
      wdata_b[0] = vb;
      n   = 0;
      got = 1'b0;
      while (!got && n < 10) begin
         @(negedge clk);
         n++;
         if (resp_b[0]) got = 1'b1;
      end
      wr_b[0] = 1'b0;
      chk("b_wr_lat", LINE_W'(n), LINE_W'(LAT_B));
      chk("b_wr_rdata", rdata_b, '0);
      @(negedge clk);
      rd_b[1]   = 1'b1;
      addr_b[1] = 16'h003C;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk("b_sust_resp", LINE_W'(resp_b), LINE_W'((k % 2 == 1) ? 2 : 0));
         if (k % 2 == 1) chk("b_sust_rdata", rdata_b, vb);
      end
      rd_b[1] = 1'b0;
      chk("b_err", LINE_W'(err_b), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
